// File: rtl/imuldiv_mul_arbiter.sv
// Two-port round-robin arbiter in front of a single iterative multiply unit.
// One transaction is outstanding at a time: the winner's operands are latched,
// issued to the unit, the result is buffered and returned to the owning port.
//
// Ports:
//   clk, reset                   clock; asynchronous active-low reset
//   req{0,1}_msg_a/_b/_val/_rdy  requester operand channels
//   resp{0,1}_msg_result/_val/_rdy  requester result channels
//   mulreq_msg_a/_b/_val/_rdy    request channel to the multiply unit
//   mulresp_msg_result/_val/_rdy response channel from the multiply unit
//   busy                         high whenever a transaction is in flight
//   owner                        port that owns the current transaction
module imuldiv_mul_arbiter #(
   parameter int unsigned W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [W-1:0]     req0_msg_a,
   input  logic [W-1:0]     req0_msg_b,
   input  logic             req0_val,
   output logic             req0_rdy,
   output logic [2*W-1:0]   resp0_msg_result,
   output logic             resp0_val,
   input  logic             resp0_rdy,
   input  logic [W-1:0]     req1_msg_a,
   input  logic [W-1:0]     req1_msg_b,
   input  logic             req1_val,
   output logic             req1_rdy,
   output logic [2*W-1:0]   resp1_msg_result,
   output logic             resp1_val,
   input  logic             resp1_rdy,
   output logic [W-1:0]     mulreq_msg_a,
   output logic [W-1:0]     mulreq_msg_b,
   output logic             mulreq_val,
   input  logic             mulreq_rdy,
   input  logic [2*W-1:0]   mulresp_msg_result,
   input  logic             mulresp_val,
   output logic             mulresp_rdy,
   output logic             busy,
   output logic             owner
);

   localparam int unsigned RW = 2 * W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   logic [1:0]    state;
   logic [1:0]    state_nxt;
   logic          prio;
   logic [W-1:0]  a_buf;
   logic [W-1:0]  b_buf;
   logic [RW-1:0] r_buf;
   logic          grant;
   logic          any_val;
   logic          resp_done;

   // Round-robin pick: a lone requester wins outright, a tie goes to prio.
   always_comb begin
      grant = 1'b0;
      if (req0_val && req1_val) begin
         grant = prio;
      end else if (req1_val) begin
         grant = 1'b1;
      end
   end

   assign any_val   = req0_val | req1_val;
   assign resp_done = owner ? resp1_rdy : resp0_rdy;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_nxt   = state;
      req0_rdy    = 1'b0;
      req1_rdy    = 1'b0;
      mulreq_val  = 1'b0;
      mulresp_rdy = 1'b0;
      resp0_val   = 1'b0;
      resp1_val   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (any_val) begin
               req0_rdy  = ~grant;
               req1_rdy  = grant;
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            mulreq_val = 1'b1;
            if (mulreq_rdy) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            mulresp_rdy = 1'b1;
            if (mulresp_val) state_nxt = ST_RESP;
         end
         ST_RESP: begin
            resp0_val = ~owner;
            resp1_val = owner;
            if (resp_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // The grant path is combinational from req*_val, so it must be
      // forced quiet while reset is held.
      if (!reset) begin
         req0_rdy = 1'b0;
         req1_rdy = 1'b0;
      end
   end

   // Operand/result buffers, ownership and round-robin pointer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_buf <= '0;
         b_buf <= '0;
         r_buf <= '0;
         owner <= 1'b0;
         prio  <= 1'b0;
      end else begin
         if (state == ST_IDLE && any_val) begin
            owner <= grant;
            a_buf <= grant ? req1_msg_a : req0_msg_a;
            b_buf <= grant ? req1_msg_b : req0_msg_b;
         end
         if (state == ST_WAIT && mulresp_val) begin
            r_buf <= mulresp_msg_result;
         end
         if (state == ST_RESP && resp_done) begin
            prio <= ~owner;
         end
      end
   end

   assign mulreq_msg_a     = a_buf;
   assign mulreq_msg_b     = b_buf;
   assign resp0_msg_result = r_buf;
   assign resp1_msg_result = r_buf;
   assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: behavioural multiply unit, per-port
// expected-result queues, directed scenarios and a randomized throttled run.
module tb_imuldiv_mul_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
   logic        req0_val, req0_rdy, req1_val, req1_rdy;
   logic [63:0] resp0_msg_result, resp1_msg_result;
   logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
   logic [31:0] mulreq_msg_a, mulreq_msg_b;
   logic        mulreq_val, mulreq_rdy;
   logic [63:0] mulresp_msg_result;
   logic        mulresp_val, mulresp_rdy;
   logic        busy, owner;

   int total = 0;
   int bad   = 0;

   imuldiv_mul_arbiter #(.W(32)) dut (
      .clk(clk), .reset(reset),
      .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
      .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
      .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
      .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
      .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
      .mulreq_rdy(mulreq_rdy),
      .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val),
      .mulresp_rdy(mulresp_rdy),
      .busy(busy), .owner(owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
   endfunction

   // Behavioural signed multiply unit with configurable latency.
   logic        u_rdy_en = 1'b1;
   int          u_lat_min = 1;
   int          u_lat_max = 1;
   logic        u_busy;
   int          u_cnt;
   logic [63:0] u_res;

   assign mulreq_rdy = u_rdy_en & ~u_busy;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         u_busy             <= 1'b0;
         u_cnt              <= 0;
         u_res              <= '0;
         mulresp_val        <= 1'b0;
         mulresp_msg_result <= '0;
      end else if (!u_busy) begin
         if (mulreq_val && mulreq_rdy) begin
            u_busy <= 1'b1;
            u_cnt  <= int'($urandom_range(u_lat_max, u_lat_min));
            u_res  <= mul_ref(mulreq_msg_a, mulreq_msg_b);
         end
      end else if (!mulresp_val) begin
         if (u_cnt <= 1) begin
            mulresp_val        <= 1'b1;
            mulresp_msg_result <= u_res;
         end else begin
            u_cnt <= u_cnt - 1;
         end
      end else if (mulresp_rdy) begin
         mulresp_val <= 1'b0;
         u_busy      <= 1'b0;
      end
   end

   // Scoreboard: expected products pushed on request handshake, popped on response.
   logic [63:0] q0[$];
   logic [63:0] q1[$];
   int          n_resp0 = 0;
   int          n_resp1 = 0;

   always @(negedge clk) begin
      logic [63:0] exp_v;
      if (!reset) begin
         q0.delete();
         q1.delete();
      end else begin
         if (req0_val && req0_rdy) q0.push_back(mul_ref(req0_msg_a, req0_msg_b));
         if (req1_val && req1_rdy) q1.push_back(mul_ref(req1_msg_a, req1_msg_b));
         if (resp0_val && resp0_rdy) begin
            total++;
            n_resp0++;
            if (q0.size() == 0) begin
               bad++;
               $display("FAIL sb_port0: got result %0h with no outstanding port0 request", resp0_msg_result);
            end else begin
               exp_v = q0.pop_front();
               if (resp0_msg_result !== exp_v) begin
                  bad++;
                  $display("FAIL sb_port0: got %0h want %0h", resp0_msg_result, exp_v);
               end
            end
         end
         if (resp1_val && resp1_rdy) begin
            total++;
            n_resp1++;
            if (q1.size() == 0) begin
               bad++;
               $display("FAIL sb_port1: got result %0h with no outstanding port1 request", resp1_msg_result);
            end else begin
               exp_v = q1.pop_front();
               if (resp1_msg_result !== exp_v) begin
                  bad++;
                  $display("FAIL sb_port1: got %0h want %0h", resp1_msg_result, exp_v);
               end
            end
         end
         if (req0_rdy || req1_rdy || resp0_val || resp1_val) begin
            total++;
            if ((req0_rdy && req1_rdy) || (resp0_val && resp1_val)) begin
               bad++;
               $display("FAIL exclusive: got rdy=%b%b val=%b%b want at most one each",
                        req0_rdy, req1_rdy, resp0_val, resp1_val);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Polls a DUT output once per cycle; leaves time 2 units after the edge.
   task automatic wait_for(input int sel, input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         #1;
         case (sel)
            0: ok = resp0_val;
            1: ok = resp1_val;
            2: ok = mulresp_rdy;
            3: ok = req0_rdy;
            default: ok = req1_rdy;
         endcase
         if (ok) break;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req0_val = 0; req1_val = 0; resp0_rdy = 0; resp1_rdy = 0;
      req0_msg_a = 0; req0_msg_b = 0; req1_msg_a = 0; req1_msg_b = 0;
      repeat (3) tick();
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         total++;
         if ({req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy, owner} !== 8'h00
             || mulreq_msg_a !== 32'd0 || resp0_msg_result !== 64'd0) begin
            bad++;
            $display("FAIL reset_idle: got ctl=%b%b%b%b%b%b%b%b opa=%0h want all 0",
                     req0_rdy, req1_rdy, resp0_val, resp1_val, mulreq_val, mulresp_rdy, busy, owner,
                     mulreq_msg_a);
         end
      end
   endtask

   task automatic test_single();
      int hs;
      int rv;
      bit saw1;
      u_lat_min = 33; u_lat_max = 33; u_rdy_en = 1;
      resp0_rdy = 1; resp1_rdy = 1;
      req0_msg_a = 32'd7; req0_msg_b = 32'd6; req0_val = 1;
      #1;
      total++;
      if (req0_rdy !== 1'b1 || req1_rdy !== 1'b0) begin
         bad++;
         $display("FAIL single_grant: got rdy=%b%b want 10", req0_rdy, req1_rdy);
      end
      tick();
      req0_val = 0;
      total++;
      if ({mulreq_val, busy, owner} !== 3'b110 || mulreq_msg_a !== 32'd7 || mulreq_msg_b !== 32'd6) begin
         bad++;
         $display("FAIL single_issue: got val/busy/owner=%b%b%b a=%0d b=%0d want 110 7 6",
                  mulreq_val, busy, owner, mulreq_msg_a, mulreq_msg_b);
      end
      hs = -1; rv = -1; saw1 = 0;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (resp1_val) saw1 = 1;
         if (mulresp_val && mulresp_rdy) hs = i;
         if (resp0_val) begin
            rv = i;
            break;
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (rv < 0 || hs < 0 || rv != hs + 1 || resp0_msg_result !== 64'd42) begin
         bad++;
         $display("FAIL single_resp: got resp cycle=%0d unit cycle=%0d result=%0d want unit+1 and 42",
                  rv, hs, resp0_msg_result);
      end
      total++;
      if (saw1) begin
         bad++;
         $display("FAIL single_misroute: got resp1_val=1 want 0");
      end
      tick();
      // Tie after port 0 completes must go to port 1; vals drop before the edge.
      req0_val = 1; req1_val = 1;
      #1;
      total++;
      if ({req0_rdy, req1_rdy, busy} !== 3'b010) begin
         bad++;
         $display("FAIL single_prio: got rdy=%b%b busy=%b want 01 0", req0_rdy, req1_rdy, busy);
      end
      req0_val = 0; req1_val = 0;
   endtask

   task automatic test_contention();
      int nresp;
      bit hs0, hs1;
      bit ord[2];
      logic [63:0] res[2];
      reset = 0;
      tick(); tick();
      reset = 1;
      u_lat_min = 4; u_lat_max = 4;
      resp0_rdy = 1; resp1_rdy = 1;
      req0_msg_a = 32'd3; req0_msg_b = 32'd5;
      req1_msg_a = 32'hFFFF_FFFE; req1_msg_b = 32'd4;
      req0_val = 1; req1_val = 1;
      nresp = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         hs0 = req0_val && req0_rdy;
         hs1 = req1_val && req1_rdy;
         if (resp0_val && resp0_rdy && nresp < 2) begin ord[nresp] = 0; res[nresp] = resp0_msg_result; nresp++; end
         if (resp1_val && resp1_rdy && nresp < 2) begin ord[nresp] = 1; res[nresp] = resp1_msg_result; nresp++; end
         if (nresp == 2) break;
         tick();
         if (hs0) req0_val = 0;
         if (hs1) req1_val = 0;
      end
      total++;
      if (nresp != 2 || ord[0] !== 1'b0 || res[0] !== 64'd15) begin
         bad++;
         $display("FAIL contend_first: got n=%0d port=%0d result=%0h want port0 15", nresp, ord[0], res[0]);
      end
      total++;
      if (nresp != 2 || ord[1] !== 1'b1 || res[1] !== 64'hFFFF_FFFF_FFFF_FFF8) begin
         bad++;
         $display("FAIL contend_second: got port=%0d result=%0h want port1 fffffffffffffff8", ord[1], res[1]);
      end
      tick();
      req0_val = 1; req1_val = 1;
      #1;
      total++;
      if ({req0_rdy, req1_rdy} !== 2'b10) begin
         bad++;
         $display("FAIL contend_again: got rdy=%b%b want 10", req0_rdy, req1_rdy);
      end
      req0_val = 0; req1_val = 0;
   endtask

   task automatic test_stalls();
      bit ok;
      tick();
      u_rdy_en = 0; u_lat_min = 3; u_lat_max = 3;
      resp0_rdy = 0; resp1_rdy = 1;
      req0_msg_a = 32'd9; req0_msg_b = 32'd11; req0_val = 1;
      tick();
      req0_val = 0;
      req1_msg_a = 32'd2; req1_msg_b = 32'd3; req1_val = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if ({mulreq_val, mulreq_msg_a, mulreq_msg_b, req0_rdy, req1_rdy} !== {1'b1, 32'd9, 32'd11, 2'b00}) begin
            bad++;
            $display("FAIL stall_issue: got val=%b a=%0d b=%0d rdy=%b%b want 1 9 11 00",
                     mulreq_val, mulreq_msg_a, mulreq_msg_b, req0_rdy, req1_rdy);
         end
         tick();
      end
      u_rdy_en = 1;
      wait_for(0, 50, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL stall_wait: got no resp0_val want resp0_val within 50 cycles");
      end
      for (int i = 0; i < 8; i++) begin
         #1;
         total++;
         if ({resp0_val, resp0_msg_result, mulresp_rdy, req0_rdy, req1_rdy, resp1_val} !==
             {1'b1, 64'd99, 4'b0000}) begin
            bad++;
            $display("FAIL stall_resp: got val=%b res=%0d mrdy=%b rdy=%b%b v1=%b want 1 99 0 00 0",
                     resp0_val, resp0_msg_result, mulresp_rdy, req0_rdy, req1_rdy, resp1_val);
         end
         tick();
      end
      resp0_rdy = 1;
      tick();
      total++;
      if (resp0_val !== 1'b0) begin
         bad++;
         $display("FAIL stall_release: got resp0_val=%b want 0", resp0_val);
      end
      wait_for(4, 20, ok);
      tick();
      req1_val = 0;
      wait_for(1, 50, ok);
      total++;
      if (!ok || resp1_msg_result !== 64'd6) begin
         bad++;
         $display("FAIL stall_port1: got ok=%0d result=%0d want 1 6", ok, resp1_msg_result);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      bit ok;
      u_lat_min = 20; u_lat_max = 20;
      req0_msg_a = 32'd5; req0_msg_b = 32'd5; req0_val = 1;
      tick();
      req0_val = 0;
      wait_for(2, 20, ok);
      tick(); tick(); tick();
      #2;
      reset = 0;
      #1;
      total++;
      if (!ok || {busy, mulresp_rdy, mulreq_val, resp0_val, req0_rdy, req1_rdy, owner} !== 7'b0
          || resp0_msg_result !== 64'd0) begin
         bad++;
         $display("FAIL midreset_async: got waitseen=%0d busy=%b mrdy=%b mval=%b res=%0h want 1 0 0 0 0",
                  ok, busy, mulresp_rdy, mulreq_val, resp0_msg_result);
      end
      tick(); tick();
      reset = 1;
      tick();
      resp1_rdy = 1;
      req1_msg_a = 32'hFFFF_FFFF; req1_msg_b = 32'd1; req1_val = 1;
      wait_for(4, 20, ok);
      tick();
      req1_val = 0;
      wait_for(1, 50, ok);
      total++;
      if (!ok || resp1_msg_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         bad++;
         $display("FAIL midreset_after: got ok=%0d result=%0h want 1 ffffffffffffffff", ok, resp1_msg_result);
      end
      tick();
   endtask

   int done_cnt;

   task automatic drive_port(input bit p, input int n);
      bit ok;
      for (int k = 0; k < n; k++) begin
         repeat ($urandom_range(3, 0)) tick();
         if (p) begin
            req1_msg_a = $urandom; req1_msg_b = $urandom; req1_val = 1;
         end else begin
            req0_msg_a = $urandom; req0_msg_b = $urandom; req0_val = 1;
         end
         ok = 0;
         for (int i = 0; i < 2000; i++) begin
            #1;
            if (p ? req1_rdy : req0_rdy) begin
               ok = 1;
               break;
            end
            @(posedge clk);
            #1;
         end
         tick();
         if (p) req1_val = 0; else req0_val = 0;
         total++;
         if (!ok) begin
            bad++;
            $display("FAIL b2b_grant: got no grant on port%0d want grant within 2000 cycles", p);
            break;
         end
      end
      done_cnt++;
   endtask

   task automatic throttle();
      while (done_cnt < 2) begin
         resp0_rdy = 1'($urandom_range(1, 0));
         resp1_rdy = 1'($urandom_range(1, 0));
         u_rdy_en  = 1'($urandom_range(1, 0));
         tick();
      end
      resp0_rdy = 1; resp1_rdy = 1; u_rdy_en = 1;
   endtask

   task automatic test_back_to_back();
      n_resp0 = 0; n_resp1 = 0; done_cnt = 0;
      u_lat_min = 1; u_lat_max = 6;
      fork
         drive_port(1'b0, 500);
         drive_port(1'b1, 500);
         throttle();
      join
      for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) tick();
      tick(); tick();
      total++;
      if (n_resp0 != 500 || n_resp1 != 500 || q0.size() != 0 || q1.size() != 0) begin
         bad++;
         $display("FAIL b2b_count: got resp=%0d/%0d left=%0d/%0d want 500/500 0/0",
                  n_resp0, n_resp1, q0.size(), q1.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_stalls();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
